// File: rtl/axis_sched_pkg.sv
// -----------------------------------------------------------------------------
// axis_sched_pkg
// Shared types and constants for the axis descriptor sequencer.
//   state_t    : sequencer FSM states
//   DIR_WR/RD  : descriptor direction encodings
//   CFG_START  : value written to the path start register
// -----------------------------------------------------------------------------
package axis_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_ADDR = 3'd1,
        S_LEN  = 3'd2,
        S_GO   = 3'd3,
        RUN    = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic DIR_WR = 1'b0;  // stream -> memory
    localparam logic DIR_RD = 1'b1;  // memory -> stream

    localparam int unsigned CFG_START = 1;

endpackage

// File: rtl/axis_sched_if.sv
// -----------------------------------------------------------------------------
// axis_sched_if
// Bundles the descriptor handshake, cfg write bus, stream monitor taps and
// status outputs of axis_sched.
//   slave  : the sequencer side (consumes descriptors, drives cfg/status)
//   master : the host/control side (offers descriptors, observes cfg/status)
// Widths must match the parameters of the axis_sched instance using it.
// -----------------------------------------------------------------------------
interface axis_sched_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int CNT_WIDTH     = 32,
    parameter int CONFIG_AWIDTH = 5,
    parameter int CONFIG_DWIDTH = 32
);
    import axis_sched_pkg::*;

    // descriptor handshake
    logic                     desc_valid;
    logic                     desc_ready;
    logic                     desc_dir;
    logic [ADDR_WIDTH-1:0]    desc_addr;
    logic [CNT_WIDTH-1:0]     desc_len;
    // cfg write bus (no backpressure)
    logic [CONFIG_AWIDTH-1:0] cfg_addr;
    logic [CONFIG_DWIDTH-1:0] cfg_data;
    logic                     cfg_valid;
    // stream taps, observed only
    logic                     wr_valid;
    logic                     wr_ready;
    logic                     rd_valid;
    logic                     rd_ready;
    // status
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [CNT_WIDTH-1:0]     remaining;

    modport slave (
        input  desc_valid, desc_dir, desc_addr, desc_len,
        input  wr_valid, wr_ready, rd_valid, rd_ready,
        output desc_ready, cfg_addr, cfg_data, cfg_valid,
        output busy, done, err, remaining
    );

    modport master (
        output desc_valid, desc_dir, desc_addr, desc_len,
        output wr_valid, wr_ready, rd_valid, rd_ready,
        input  desc_ready, cfg_addr, cfg_data, cfg_valid,
        input  busy, done, err, remaining
    );

endinterface

// File: rtl/axis_sched_wdog.sv
// -----------------------------------------------------------------------------
// axis_sched_wdog
// Idle-cycle watchdog: counts enabled cycles without activity and pulses
// tick_o on the TIMEOUT-th consecutive idle cycle.
//   clk, rst : clock, asynchronous active-low reset
//   en_i     : count while high; counter is cleared while low
//   clr_i    : activity seen this cycle; restarts the count
//   tick_o   : combinational pulse, high in the cycle that reaches TIMEOUT
// -----------------------------------------------------------------------------
module axis_sched_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The cycle holding TIMEOUT-1 is the TIMEOUT-th idle cycle.
    assign tick_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i) begin
            cnt_d = '0;
        end else if (!tick_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_sched.sv
// -----------------------------------------------------------------------------
// axis_sched
// Descriptor sequencer for the axis stream engine. Accepts one descriptor,
// programs address, length and start registers over the cfg bus on the three
// cycles after accept, then counts stream beats of the selected direction
// until the transfer is complete.
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : axis_sched_if.slave (descriptor in, cfg out, stream taps, status)
// Optional feature: define AXIS_SCHED_TIMEOUT_EN to add an idle-beat watchdog
// that ends a stalled transfer after TIMEOUT RUN cycles with err set.
// -----------------------------------------------------------------------------
module axis_sched #(
    parameter int CONFIG_ID_WR  = 1,
    parameter int CONFIG_ID_RD  = 2,
    parameter int CONFIG_ADDR   = 23,
    parameter int CONFIG_DATA   = 24,
    parameter int CONFIG_AWIDTH = 5,
    parameter int CONFIG_DWIDTH = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int CNT_WIDTH     = 32,
    parameter int TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        rst,
    axis_sched_if.slave bus
);
    import axis_sched_pkg::*;

    state_t                   state_q, state_d;
    logic                     dir_q, dir_d;
    logic [CNT_WIDTH-1:0]     len_q, len_d;
    logic [CNT_WIDTH-1:0]     remaining_q, remaining_d;
    logic [CONFIG_AWIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [CONFIG_DWIDTH-1:0] cfg_data_q, cfg_data_d;
    logic                     cfg_valid_q, cfg_valid_d;
    logic                     err_q, err_d;
    logic                     beat;
    logic                     timeout_tick;

    // Only the handshake of the descriptor's own direction counts.
    assign beat = (dir_q == DIR_RD) ? (bus.rd_valid & bus.rd_ready)
                                    : (bus.wr_valid & bus.wr_ready);

`ifdef AXIS_SCHED_TIMEOUT_EN
    axis_sched_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == RUN),
        .clr_i  (beat),
        .tick_o (timeout_tick)
    );
`else
    assign timeout_tick = 1'b0;
    wire unused_timeout = |32'(TIMEOUT);
`endif

    // cfg outputs are registered and set one state ahead, so cfg_valid lines
    // up with S_ADDR..S_GO and cfg_addr/cfg_data hold their last write after.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_data_d  = cfg_data_q;
        cfg_valid_d = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (bus.desc_valid) begin
                    dir_d       = bus.desc_dir;
                    len_d       = bus.desc_len;
                    remaining_d = bus.desc_len;
                    err_d       = 1'b0;
                    if (bus.desc_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d     = S_ADDR;
                        cfg_valid_d = 1'b1;
                        cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_ADDR);
                        cfg_data_d  = CONFIG_DWIDTH'(bus.desc_addr);
                    end
                end
            end
            S_ADDR: begin
                state_d     = S_LEN;
                cfg_valid_d = 1'b1;
                cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_DATA);
                cfg_data_d  = CONFIG_DWIDTH'(len_q);
            end
            S_LEN: begin
                state_d     = S_GO;
                cfg_valid_d = 1'b1;
                cfg_addr_d  = (dir_q == DIR_RD) ? CONFIG_AWIDTH'(CONFIG_ID_RD)
                                                : CONFIG_AWIDTH'(CONFIG_ID_WR);
                cfg_data_d  = CONFIG_DWIDTH'(CFG_START);
            end
            S_GO: begin
                state_d = RUN;
            end
            RUN: begin
                if (beat && remaining_q != '0) begin
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end else if (timeout_tick) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dir_q       <= DIR_WR;
            len_q       <= '0;
            remaining_q <= '0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            cfg_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            cfg_valid_q <= cfg_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.desc_ready = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.cfg_addr   = cfg_addr_q;
    assign bus.cfg_data   = cfg_data_q;
    assign bus.cfg_valid  = cfg_valid_q;
    assign bus.err        = err_q;
    assign bus.remaining  = remaining_q;

endmodule
